// File: rtl/baw_round_sched.sv
// Round/turn sequencer for the two-player black-and-white bidding game.
// Optional: define BAW_HIDE_BID_EN to blank p1_bid/p2_bid outside MATCH and GAME.
module baw_round_sched #(
    parameter int unsigned START_PTS = 40,
    parameter int unsigned ROUNDS    = 9,
    parameter int unsigned WIN_SCORE = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btnCenter,
    input  logic        btnTop,
    input  logic        btnBottom,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic [15:0] sw,
    output logic [2:0]  state,
    output logic [3:0]  round,
    output logic [3:0]  p1_bid,
    output logic [3:0]  p2_bid,
    output logic [7:0]  p1_pts,
    output logic [7:0]  p2_pts,
    output logic [3:0]  p1_score,
    output logic [3:0]  p2_score,
    output logic [1:0]  round_winner,
    output logic [1:0]  game_winner,
    output logic        finish,
    output logic        bid_err
);

    typedef enum logic [2:0] {
        StInit   = 3'd0,
        StRasp   = 3'd1,
        StBawp   = 3'd2,
        StP1Turn = 3'd3,
        StP2Turn = 3'd4,
        StMatch  = 3'd5,
        StGame   = 3'd6
    } state_e;

    // Event vector bit order doubles as priority order (bit 0 highest).
    localparam int unsigned EvBottom = 0;
    localparam int unsigned EvCenter = 1;
    localparam int unsigned EvTop    = 2;
    localparam int unsigned EvLeft   = 3;
    localparam int unsigned EvRight  = 4;

    localparam logic [7:0] PtsInit  = 8'(START_PTS);
    localparam logic [3:0] RoundMax = 4'(ROUNDS);
    localparam logic [3:0] ScoreWin = 4'(WIN_SCORE);

    state_e      state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [3:0]  p1_bid_q, p1_bid_d, p2_bid_q, p2_bid_d;
    logic [7:0]  p1_pts_q, p1_pts_d, p2_pts_q, p2_pts_d;
    logic [3:0]  p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [1:0]  round_winner_q, round_winner_d;
    logic [1:0]  game_winner_q, game_winner_d;
    logic        finish_q, finish_d;
    logic        bid_err_q, bid_err_d;
    logic        p1_lock_q, p1_lock_d, p2_lock_q, p2_lock_d;
    logic [4:0]  btn_prev_q, btn_prev_d;

    logic [4:0]  btn_now;
    logic [4:0]  btn_ev;
    logic [4:0]  ev_mask;
    logic [4:0]  ev_act;
    logic [4:0]  grant;

    logic [4:0]  sw_cnt;
    logic [3:0]  sw_val;
    logic [7:0]  turn_pts;
    logic        bid_ok;

    logic [3:0]  m_p1_score, m_p2_score;
    logic [1:0]  m_winner;
    logic        m_finish;

    assign btn_now    = {btnRight, btnLeft, btnTop, btnCenter, btnBottom};
    assign btn_ev     = btn_now & ~btn_prev_q;
    assign btn_prev_d = btn_now;

    // Priority is resolved only among events the current state reacts to,
    // so an ignored higher-priority press cannot mask a meaningful one.
    always_comb begin
        ev_mask = 5'b00000;
        ev_mask[EvBottom] = 1'b1;
        unique case (state_q)
            StInit:   ev_mask[EvCenter] = 1'b1;
            StRasp:   ev_mask[EvTop] = 1'b1;
            StBawp: begin
                ev_mask[EvCenter] = 1'b1;
                ev_mask[EvLeft]   = 1'b1;
                ev_mask[EvRight]  = 1'b1;
            end
            StP1Turn, StP2Turn: begin
                ev_mask[EvTop]   = 1'b1;
                ev_mask[EvLeft]  = 1'b1;
                ev_mask[EvRight] = 1'b1;
            end
            StMatch:  ev_mask[EvLeft] = 1'b1;
            default:  ev_mask = 5'b00001;
        endcase
    end

    assign ev_act = btn_ev & ev_mask;
    assign grant  = ev_act & (~ev_act + 5'd1);

    always_comb begin
        sw_cnt = 5'd0;
        sw_val = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (sw[i]) begin
                sw_cnt = sw_cnt + 5'd1;
                sw_val = 4'(i);
            end
        end
    end

    assign turn_pts = (state_q == StP2Turn) ? p2_pts_q : p1_pts_q;
    assign bid_ok   = (sw_cnt <= 5'd1) && ({4'd0, sw_val} <= turn_pts);

    // Round arbitration evaluated from the locked bids, applied on MATCH entry.
    always_comb begin
        m_p1_score = p1_score_q;
        m_p2_score = p2_score_q;
        m_winner   = 2'd0;
        if (p1_bid_q > p2_bid_q) begin
            m_winner = 2'd1;
            if (p1_score_q < ScoreWin) m_p1_score = p1_score_q + 4'd1;
        end else if (p2_bid_q > p1_bid_q) begin
            m_winner = 2'd2;
            if (p2_score_q < ScoreWin) m_p2_score = p2_score_q + 4'd1;
        end
        m_finish = (m_p1_score >= ScoreWin) || (m_p2_score >= ScoreWin) ||
                   (round_q >= RoundMax);
    end

    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        p1_bid_d       = p1_bid_q;
        p2_bid_d       = p2_bid_q;
        p1_pts_d       = p1_pts_q;
        p2_pts_d       = p2_pts_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_winner_d = round_winner_q;
        game_winner_d  = game_winner_q;
        finish_d       = finish_q;
        bid_err_d      = 1'b0;
        p1_lock_d      = p1_lock_q;
        p2_lock_d      = p2_lock_q;

        if (grant[EvBottom]) begin
            state_d        = StInit;
            round_d        = 4'd1;
            p1_bid_d       = 4'd0;
            p2_bid_d       = 4'd0;
            p1_pts_d       = PtsInit;
            p2_pts_d       = PtsInit;
            p1_score_d     = 4'd0;
            p2_score_d     = 4'd0;
            round_winner_d = 2'd0;
            game_winner_d  = 2'd0;
            finish_d       = 1'b0;
            p1_lock_d      = 1'b0;
            p2_lock_d      = 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (grant[EvCenter]) state_d = StRasp;
                end
                StRasp: begin
                    if (grant[EvTop]) begin
                        state_d        = StBawp;
                        p1_lock_d      = 1'b0;
                        p2_lock_d      = 1'b0;
                        p1_bid_d       = 4'd0;
                        p2_bid_d       = 4'd0;
                        round_winner_d = 2'd0;
                    end
                end
                StBawp: begin
                    if (grant[EvCenter]) begin
                        if (p1_lock_q && p2_lock_q) begin
                            state_d        = StMatch;
                            p1_pts_d       = p1_pts_q - {4'd0, p1_bid_q};
                            p2_pts_d       = p2_pts_q - {4'd0, p2_bid_q};
                            p1_score_d     = m_p1_score;
                            p2_score_d     = m_p2_score;
                            round_winner_d = m_winner;
                            finish_d       = m_finish;
                        end
                    end else if (grant[EvLeft]) begin
                        if (!p1_lock_q) state_d = StP1Turn;
                    end else if (grant[EvRight]) begin
                        if (!p2_lock_q) state_d = StP2Turn;
                    end
                end
                StP1Turn, StP2Turn: begin
                    if (grant[EvTop]) begin
                        if (bid_ok) begin
                            state_d = StBawp;
                            if (state_q == StP1Turn) begin
                                p1_bid_d  = sw_val;
                                p1_lock_d = 1'b1;
                            end else begin
                                p2_bid_d  = sw_val;
                                p2_lock_d = 1'b1;
                            end
                        end else begin
                            bid_err_d = 1'b1;
                        end
                    end else if (grant[EvLeft] || grant[EvRight]) begin
                        state_d = StBawp;
                    end
                end
                StMatch: begin
                    if (grant[EvLeft]) begin
                        if (finish_q) begin
                            state_d = StGame;
                            if (p1_score_q > p2_score_q) begin
                                game_winner_d = 2'd1;
                            end else if (p2_score_q > p1_score_q) begin
                                game_winner_d = 2'd2;
                            end else begin
                                game_winner_d = 2'd0;
                            end
                        end else begin
                            state_d = StRasp;
                            if (round_q < RoundMax) round_d = round_q + 4'd1;
                        end
                    end
                end
                StGame: begin
                    state_d = StGame;
                end
                default: begin
                    state_d = StInit;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StInit;
            round_q        <= 4'd1;
            p1_bid_q       <= 4'd0;
            p2_bid_q       <= 4'd0;
            p1_pts_q       <= PtsInit;
            p2_pts_q       <= PtsInit;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            round_winner_q <= 2'd0;
            game_winner_q  <= 2'd0;
            finish_q       <= 1'b0;
            bid_err_q      <= 1'b0;
            p1_lock_q      <= 1'b0;
            p2_lock_q      <= 1'b0;
            btn_prev_q     <= 5'd0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            p1_bid_q       <= p1_bid_d;
            p2_bid_q       <= p2_bid_d;
            p1_pts_q       <= p1_pts_d;
            p2_pts_q       <= p2_pts_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_winner_q <= round_winner_d;
            game_winner_q  <= game_winner_d;
            finish_q       <= finish_d;
            bid_err_q      <= bid_err_d;
            p1_lock_q      <= p1_lock_d;
            p2_lock_q      <= p2_lock_d;
            btn_prev_q     <= btn_prev_d;
        end
    end

    assign state        = state_q;
    assign round        = round_q;
    assign p1_pts       = p1_pts_q;
    assign p2_pts       = p2_pts_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_winner = round_winner_q;
    assign game_winner  = game_winner_q;
    assign finish       = finish_q;
    assign bid_err      = bid_err_q;

`ifdef BAW_HIDE_BID_EN
    logic bid_visible;
    assign bid_visible = (state_q == StMatch) || (state_q == StGame);
    assign p1_bid      = bid_visible ? p1_bid_q : 4'd0;
    assign p2_bid      = bid_visible ? p2_bid_q : 4'd0;
`else
    assign p1_bid = p1_bid_q;
    assign p2_bid = p2_bid_q;
`endif

endmodule

// File: doc/baw_round_sched.md
Name: baw_round_sched

Overview:
- Round/turn sequencer for the two-player black-and-white bidding game.
- Turns debounced push-button levels and the 16-bit one-hot switch bank into a game state machine.
- Latches each player's secret bid, then arbitrates the round winner and tracks the point budgets and scores.
- Sits between the board I/O and the display/LED formatter, which consume its state and value outputs.

Parameters:
- START_PTS, 40, initial point budget per player (max 255).
- ROUNDS, 9, maximum rounds per game (max 15).
- WIN_SCORE, 5, round wins that end the game early.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btnCenter, btnTop, btnBottom, btnLeft, btnRight  in  1 each  debounced button levels
- sw  in  16  bid switches; value = index of the single set bit, all-zero = bid 0
- state  out  3  0 INIT, 1 RASP, 2 BAWP, 3 P1_TURN, 4 P2_TURN, 5 MATCH, 6 GAME
- round  out  4  current round, 1-based
- p1_bid, p2_bid  out  4  latched bids
- p1_pts, p2_pts  out  8  remaining budgets
- p1_score, p2_score  out  4  rounds won
- round_winner  out  2  0 draw, 1 P1, 2 P2; valid in MATCH
- game_winner  out  2  0 draw, 1 P1, 2 P2; valid in GAME
- finish  out  1  game over
- bid_err  out  1  one-cycle pulse on a rejected bid

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, round=1, pts=START_PTS, every other output 0.
  - Both lock flags and all button history registers cleared.
- Button decoding:
  - Each button is registered; an event is btn=1 with previous sample 0.
  - Each press acts once and takes effect at the next clock edge.
  - A held button does not repeat.
  - Simultaneous events resolve by priority: Bottom > Center > Top > Left > Right. Only the winner acts; the rest are dropped.
- Soft restart: a Bottom event in any state re-applies the reset values synchronously.
- Transitions (any event not listed is ignored):
  - INIT: Center -> RASP.
  - RASP: Top -> BAWP; clears both lock flags, both bids, round_winner.
  - BAWP: Left -> P1_TURN if P1 unlocked. Right -> P2_TURN if P2 unlocked.
  - BAWP: Center -> MATCH only when both are locked; otherwise stay.
  - P1_TURN / P2_TURN, on Top:
    - If sw has 0 or 1 bits set and value <= own pts: latch the bid, set the lock flag, go to BAWP.
    - Otherwise pulse bid_err for 1 cycle and stay in the same state.
    - Left/Right in these states -> BAWP without locking.
- MATCH entry (same edge as the transition), all registered together:
  - Each player's pts reduced by own bid.
  - Higher bid wins: its score +1 and round_winner set. Equal bids -> round_winner=0, no score change.
  - finish=1 if either score reaches WIN_SCORE or round==ROUNDS.
- MATCH exit, on Left:
  - finish=1 -> GAME; game_winner from the score compare (equal -> 0).
  - finish=0 -> RASP with round+1.
- GAME: only Bottom acts (soft restart).
- Arithmetic:
  - pts never underflow, since bid <= pts is enforced at latch.
  - Scores saturate at WIN_SCORE.
  - round never exceeds ROUNDS.
- Reset mid-operation discards any latched bids; no partial round is scored.

Optional Feature:
- BAW_HIDE_BID_EN defined: p1_bid/p2_bid output 0 in every state except MATCH and GAME, so the opponent cannot read a locked bid. Internal latches are unchanged.
- Macro undefined: p1_bid/p2_bid show the latched values as soon as they lock.

Test Plan:
- Reset release -> state=0, round=1, p1_pts=p2_pts=40, scores 0, finish=0; a held btnCenter produces exactly one INIT->RASP transition.
- Center, Top, Left, sw=16'h2000, Top, Right, sw=16'h1000, Top, Center -> state=5, p1_bid=13, p2_bid=12, round_winner=1, p1_score=1, p1_pts=27, p2_pts=28; then Left -> state=1, round=2.
- Tie round: P1 sw=16'h0010, P2 sw=16'h0010 -> round_winner=0, scores unchanged, both pts reduced by 4; Center in BAWP with only P1 locked -> state stays 2.
- Bid rejects, each giving a 1-cycle bid_err with state=3 held:
  - sw=16'h0003 with Top in P1_TURN.
  - p1_pts=5 with sw=16'h0200.
- Five consecutive P1 wins at bid 1 vs 0 -> finish=1 after round 5; Left -> state=6, game_winner=1; Bottom -> all reset values.
- Ties for 9 rounds (bids 0) -> finish after round 9, game_winner=0; Left and Top simultaneously in BAWP -> P1_TURN entered. With BAW_HIDE_BID_EN, p1_bid=0 in BAWP after lock and shows 13 in MATCH.
